// File: rtl/video_timing_pkg.sv
// Shared timing constants, pattern encodings and the colour-bar table for the
// raster timing generator and its pattern source.
package video_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int HD_H_ACTIVE  = 1280;
    localparam int HD_H_FP      = 110;
    localparam int HD_H_SYNC    = 40;
    localparam int HD_H_BP      = 220;
    localparam int HD_V_ACTIVE  = 720;
    localparam int HD_V_FP      = 5;
    localparam int HD_V_SYNC    = 5;
    localparam int HD_V_BP      = 20;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'b00,
        PAT_CHECK = 2'b01,
        PAT_RAMP  = 2'b10,
        PAT_SOLID = 2'b11
    } pattern_t;

    // White, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_COLORS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    // Index 8 and above marks the columns past the last full bar.
    function automatic logic [23:0] bar_color(input logic [3:0] idx);
        return idx[3] ? 24'h000000 : BAR_COLORS[idx[2:0]];
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Test-pattern source: colour for the pixel the counters currently hold.
// Bars are tracked with a running within-bar counter instead of dividing x.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int BAR_W = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] x,
    input  logic [10:0] y,
    input  logic        visible,
    input  pattern_t    pattern,
    input  logic [23:0] solid_rgb,
    output logic [23:0] rgb
);

    localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

    logic [11:0] bar_pos_q;
    logic [3:0]  bar_idx_q;
    logic [11:0] bar_pos;
    logic [3:0]  bar_idx;

    // Only bit 5 of y selects the checker row.
    logic unused_y_bits;
    assign unused_y_bits = ^{y[10:6], y[4:0]};

    // Column 0 restarts the bar sequence, so the registers describe column x
    // as long as x advances by one per clock.
    always_comb begin
        bar_pos = (x == 12'd0) ? 12'd0 : bar_pos_q;
        bar_idx = (x == 12'd0) ? 4'd0  : bar_idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bar_pos_q <= '0;
            bar_idx_q <= '0;
        end else if (bar_pos == BAR_LAST) begin
            bar_pos_q <= '0;
            bar_idx_q <= bar_idx[3] ? bar_idx : bar_idx + 4'd1;
        end else begin
            bar_pos_q <= bar_pos + 12'd1;
            bar_idx_q <= bar_idx;
        end
    end

    always_comb begin
        rgb = 24'h000000;
        if (visible) begin
            case (pattern)
                PAT_BARS:  rgb = bar_color(bar_idx);
                PAT_CHECK: rgb = (x[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
                PAT_RAMP:  rgb = {3{x[7:0]}};
                PAT_SOLID: rgb = solid_rgb;
                default:   rgb = 24'h000000;
            endcase
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, sync and data-enable decode,
// frame-latched pattern select and one output register stage.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [1:0]  pattern,
    input  logic [23:0] solid_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start,
    output logic [11:0] x,
    output logic [10:0] y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_cnt;
    logic [10:0] v_cnt;
    pattern_t    pat_shadow;
    logic [23:0] solid_shadow;
    pattern_t    pat_eff;
    logic [23:0] solid_eff;
    logic        origin;
    logic        visible;
    logic        in_hs;
    logic        in_vs;
    logic [23:0] pix_rgb;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    always_comb begin
        origin  = (h_cnt == 12'd0) && (v_cnt == 11'd0);
        visible = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        in_hs   = (h_cnt >= HS_START) && (h_cnt < HS_END);
        in_vs   = (v_cnt >= VS_START) && (v_cnt < VS_END);
    end

    // Pixel (0,0) already uses the port value being latched on that edge.
    assign pat_eff   = origin ? pattern_t'(pattern) : pat_shadow;
    assign solid_eff = origin ? solid_rgb : solid_shadow;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            pat_shadow   <= PAT_BARS;
            solid_shadow <= '0;
        end else if (origin) begin
            pat_shadow   <= pattern_t'(pattern);
            solid_shadow <= solid_rgb;
        end
    end

    video_pattern_gen #(
        .BAR_W(H_ACTIVE / 8)
    ) u_pattern (
        .clk      (pixel_clk),
        .rst      (rst),
        .x        (h_cnt),
        .y        (v_cnt),
        .visible  (visible),
        .pattern  (pat_eff),
        .solid_rgb(solid_eff),
        .rgb      (pix_rgb)
    );

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hsync              <= ~HS_POL;
            vsync              <= ~VS_POL;
            active             <= 1'b0;
            {red, green, blue} <= '0;
            frame_start        <= 1'b0;
            x                  <= '0;
            y                  <= '0;
        end else begin
            hsync              <= in_hs ? HS_POL : ~HS_POL;
            vsync              <= in_vs ? VS_POL : ~VS_POL;
            active             <= visible;
            {red, green, blue} <= pix_rgb;
            frame_start        <= origin;
            x                  <= h_cnt;
            y                  <= v_cnt;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced raster (84x48 total,
// 70x40 visible) so several whole frames are walked pixel by pixel.
module tb_video_timing_gen;

    localparam int HA = 70;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 4;
    localparam int VA = 40;
    localparam int VF = 2;
    localparam int VS = 3;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 84
    localparam int VT = VA + VF + VS + VB;   // 48
    localparam int FRAME = HT * VT;          // 4032
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;

    logic        pixel_clk;
    logic        rst;
    logic [1:0]  pattern;
    logic [23:0] solid_rgb;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        frame_start;
    logic [11:0] x;
    logic [10:0] y;

    int tests;
    int fails;

    logic [23:0] bar_tab [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HSP), .VS_POL(VSP)
    ) dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .pattern    (pattern),
        .solid_rgb  (solid_rgb),
        .hsync      (hsync),
        .vsync      (vsync),
        .active     (active),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .frame_start(frame_start),
        .x          (x),
        .y          (y)
    );

    // Clock and reset
    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    initial begin
        rst       = 1'b1;
        pattern   = 2'b00;
        solid_rgb = 24'h000000;
    end

    function automatic logic [23:0] exp_rgb(input logic [1:0] p, input logic [23:0] s,
                                            input int hx, input int vy);
        logic [7:0] xb;
        xb = 8'(hx);
        if (hx >= HA || vy >= VA) return 24'h000000;
        case (p)
            2'b00:   return (hx >= 64) ? 24'h000000 : bar_tab[hx / 8];
            2'b01:   return ((((hx >> 5) ^ (vy >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            2'b10:   return {xb, xb, xb};
            default: return s;
        endcase
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge pixel_clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge pixel_clk);
            tests++;
            if (active !== 1'b0 || hsync !== ~HSP || vsync !== ~VSP || frame_start !== 1'b0) begin
                fails++;
                $display("FAIL reset_ctl: act=%b hs=%b vs=%b fs=%b, want 0 %b %b 0",
                         active, hsync, vsync, frame_start, ~HSP, ~VSP);
            end
            tests++;
            if ({red, green, blue} !== 24'h0 || x !== 12'd0 || y !== 11'd0) begin
                fails++;
                $display("FAIL reset_data: rgb=%h x=%0d y=%0d, want 0 0 0",
                         {red, green, blue}, x, y);
            end
        end
    endtask

    // Walks one frame starting at the negedge that shows pixel (0,0); optionally
    // changes the inputs at output cycle chg_at. Ends at the next frame's (0,0).
    task automatic run_frame(input string name, input logic [1:0] pat_exp,
                             input logic [23:0] sol_exp, input int chg_at,
                             input logic [1:0] chg_pat, input logic [23:0] chg_sol);
        int act_cnt;
        int hx;
        int vy;
        logic [23:0] want;
        act_cnt = 0;
        for (int c = 0; c < FRAME; c++) begin
            hx = c % HT;
            vy = c / HT;
            want = exp_rgb(pat_exp, sol_exp, hx, vy);
            if (active === 1'b1) act_cnt++;
            tests++;
            if (x !== 12'(hx) || y !== 11'(vy)) begin
                fails++;
                $display("FAIL %s_xy: got (%0d,%0d) want (%0d,%0d)", name, x, y, hx, vy);
            end
            tests++;
            if (active !== (hx < HA && vy < VA)) begin
                fails++;
                $display("FAIL %s_active: (%0d,%0d) got %b", name, hx, vy, active);
            end
            tests++;
            if (hsync !== ((hx >= HA + HF && hx < HA + HF + HS) ? HSP : ~HSP)) begin
                fails++;
                $display("FAIL %s_hsync: (%0d,%0d) got %b", name, hx, vy, hsync);
            end
            tests++;
            if (vsync !== ((vy >= VA + VF && vy < VA + VF + VS) ? VSP : ~VSP)) begin
                fails++;
                $display("FAIL %s_vsync: (%0d,%0d) got %b", name, hx, vy, vsync);
            end
            tests++;
            if (frame_start !== (c == 0)) begin
                fails++;
                $display("FAIL %s_fs: (%0d,%0d) got %b", name, hx, vy, frame_start);
            end
            tests++;
            if ({red, green, blue} !== want) begin
                fails++;
                $display("FAIL %s_rgb: (%0d,%0d) got %h want %h", name, hx, vy,
                         {red, green, blue}, want);
            end
            if (c == chg_at) begin
                pattern   = chg_pat;
                solid_rgb = chg_sol;
            end
            @(negedge pixel_clk);
        end
        tests++;
        if (frame_start !== 1'b1 || x !== 12'd0 || y !== 11'd0) begin
            fails++;
            $display("FAIL %s_period: after %0d cycles fs=%b x=%0d y=%0d, want 1 0 0",
                     name, FRAME, frame_start, x, y);
        end
        tests++;
        if (act_cnt != HA * VA) begin
            fails++;
            $display("FAIL %s_active_count: got %0d want %0d", name, act_cnt, HA * VA);
        end
    endtask

    task automatic test_first_frame();
        rst = 1'b0;
        @(negedge pixel_clk);
        run_frame("bars_first", 2'b00, 24'h0, -1, 2'b00, 24'h0);
    endtask

    task automatic test_pattern_changes();
        run_frame("bars_then_solid", 2'b00, 24'h0, 20 * HT, 2'b11, 24'h123456);
        run_frame("solid", 2'b11, 24'h123456, 20 * HT, 2'b01, 24'hABCDEF);
        run_frame("check", 2'b01, 24'hABCDEF, 20 * HT, 2'b10, 24'hABCDEF);
        run_frame("ramp", 2'b10, 24'hABCDEF, -1, 2'b10, 24'hABCDEF);
    endtask

    task automatic test_mid_reset();
        repeat (20 * HT + 30) @(negedge pixel_clk);
        tests++;
        if (x !== 12'd30 || y !== 11'd20) begin
            fails++;
            $display("FAIL pre_reset_pos: got (%0d,%0d) want (30,20)", x, y);
        end
        rst = 1'b1;
        pattern = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge pixel_clk);
            tests++;
            if (active !== 1'b0 || hsync !== ~HSP || vsync !== ~VSP || frame_start !== 1'b0 ||
                {red, green, blue} !== 24'h0 || x !== 12'd0 || y !== 11'd0) begin
                fails++;
                $display("FAIL mid_reset_hold: act=%b hs=%b vs=%b fs=%b rgb=%h x=%0d y=%0d",
                         active, hsync, vsync, frame_start, {red, green, blue}, x, y);
            end
        end
        rst = 1'b0;
        @(negedge pixel_clk);
        tests++;
        if (frame_start !== 1'b1 || active !== 1'b1 || {red, green, blue} !== 24'hFFFFFF) begin
            fails++;
            $display("FAIL mid_reset_release: fs=%b act=%b rgb=%h want 1 1 ffffff",
                     frame_start, active, {red, green, blue});
        end
        run_frame("post_reset", 2'b00, 24'h0, -1, 2'b00, 24'h0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_first_frame();
        test_pattern_changes();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
